// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: run-control bus between board controls/CPU and cpu_run_ctrl.
//   sw_run, btn_step : raw asynchronous switch/button levels
//   halt_req         : synchronous halt request from the CPU
//   pc, bp_addr, bp_en : breakpoint compare inputs
//   cpu_ce           : CPU clock enable, one high cycle = one instruction advance
//   ctrl_state       : HALT=00 RUN=01 STEP=10 BREAK=11
//   halted           : high in HALT or BREAK
//   ce_count         : number of cpu_ce pulses issued (wraps)
//   master drives the inputs; slave is the controller side.
interface cpu_run_ctrl_if;
   logic        sw_run;
   logic        btn_step;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] bp_addr;
   logic        bp_en;
   logic        cpu_ce;
   logic [1:0]  ctrl_state;
   logic        halted;
   logic [31:0] ce_count;
   modport master (
      output sw_run, btn_step, halt_req, pc, bp_addr, bp_en,
      input  cpu_ce, ctrl_state, halted, ce_count
   );
   modport slave (
      input  sw_run, btn_step, halt_req, pc, bp_addr, bp_en,
      output cpu_ce, ctrl_state, halted, ce_count
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/single-step/breakpoint controller producing the CPU clock enable.
//   clk_in : single clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : cpu_run_ctrl_if.slave (switch/button/halt/breakpoint in, cpu_ce/state/count out)
//   DIV        : clk_in cycles per cpu_ce pulse in RUN (>= 1)
//   DEB_CYCLES : stable cycles needed before the debounced level follows the input
//   Optional feature macro CPU_RUN_CTRL_BREAKPOINT_EN enables the pc == bp_addr breakpoint.
module cpu_run_ctrl #(
   parameter int DIV        = 4,
   parameter int DEB_CYCLES = 16
) (
   input logic           clk_in,
   input logic           reset,
   cpu_run_ctrl_if.slave bus
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11} state_t;

   // bit 0 = run switch, bit 1 = step button
   logic [1:0]         sync1_q, sync2_q, db_q;
   logic [1:0][DW-1:0] dcnt_q;
   logic               step_prev_q;
   state_t             state_q;
   logic [CW-1:0]      rate_q;
   logic [31:0]        ce_count_q;
   logic               run_db, step_pulse, bp_hit, ce;

   // Debounce counter restarts whenever the synchronized input agrees with the
   // current level, so only an unbroken run of DEB_CYCLES differing samples flips it.
   always_ff @(posedge clk_in or negedge reset)
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         dcnt_q      <= '0;
         step_prev_q <= 1'b0;
      end else begin
         sync1_q     <= {bus.btn_step, bus.sw_run};
         sync2_q     <= sync1_q;
         step_prev_q <= db_q[1];
         for (int i = 0; i < 2; i++)
            if (sync2_q[i] == db_q[i])
               dcnt_q[i] <= '0;
            else if (dcnt_q[i] == DEB_MAX) begin
               db_q[i]   <= sync2_q[i];
               dcnt_q[i] <= '0;
            end else
               dcnt_q[i] <= dcnt_q[i] + 1'b1;
      end

   assign run_db     = db_q[0];
   assign step_pulse = db_q[1] & ~step_prev_q;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
   assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr) && (state_q == RUN);
`else
   logic unused_bp;
   assign unused_bp = ^{bus.pc, bus.bp_addr, bus.bp_en};
   assign bp_hit    = 1'b0;
`endif

   // A pulse due on the same cycle as a halt or breakpoint is suppressed so the
   // CPU never advances past the stopping instruction.
   assign ce = (state_q == STEP) ||
               ((state_q == RUN) && (rate_q == CNT_MAX) && !bus.halt_req && !bp_hit);

   // BREAK only leaves via STEP or HALT, so HALT->RUN is the only RUN entry and
   // the only place the rate counter needs clearing.
   always_ff @(posedge clk_in or negedge reset)
      if (!reset) begin
         state_q    <= HALT;
         rate_q     <= '0;
         ce_count_q <= '0;
      end else begin
         ce_count_q <= ce_count_q + {31'd0, ce};
         case (state_q)
            HALT:
               if (run_db) begin
                  state_q <= RUN;
                  rate_q  <= '0;
               end else if (step_pulse)
                  state_q <= STEP;
            RUN:
               if (bus.halt_req || bp_hit)
                  state_q <= BRK;
               else if (!run_db)
                  state_q <= HALT;
               else
                  rate_q <= (rate_q == CNT_MAX) ? '0 : rate_q + 1'b1;
            STEP:
               state_q <= HALT;
            default:
               if (step_pulse)
                  state_q <= STEP;
               else if (!run_db)
                  state_q <= HALT;
         endcase
      end

   assign bus.cpu_ce     = ce;
   assign bus.ctrl_state = state_q;
   assign bus.halted     = (state_q == HALT) || (state_q == BRK);
   assign bus.ce_count   = ce_count_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl (DIV=4, DEB_CYCLES=16).
module tb_cpu_run_ctrl;
   localparam int DIV = 4;
   localparam int DEB = 16;
   localparam logic [1:0] S_HALT = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_BRK = 2'b11;

   typedef struct {
      logic [1:0]  st;
      logic [31:0] cnt;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b0;
   int          tests  = 0;
   int          fails  = 0;
   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] exp_cnt = '0;
   int          k;

   cpu_run_ctrl_if bus();

   cpu_run_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
      .clk_in(clk_in),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk_in = ~clk_in;

   // Every cpu_ce pulse must match the next expected pulse pushed by the tests.
   always @(negedge clk_in)
      if (bus.cpu_ce === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pulse_unexpected: state=%0d ce_count=%h, required no pulse", bus.ctrl_state, bus.ce_count);
         end else begin
            e = exp_q.pop_front();
            if (bus.ctrl_state !== e.st || bus.ce_count !== e.cnt) begin
               fails++;
               $display("FAIL pulse: state=%0d ce_count=%h, required state=%0d ce_count=%h", bus.ctrl_state, bus.ce_count, e.st, e.cnt);
            end
         end
      end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      bus.sw_run = 0; bus.btn_step = 0; bus.halt_req = 0;
      bus.pc = '0; bus.bp_addr = '0; bus.bp_en = 0;
      reset = 0;
      repeat (3) tick();
      tests++; if (bus.ctrl_state !== S_HALT) begin fails++; $display("FAIL reset_state: got %0d, required 0", bus.ctrl_state); end
      tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL reset_halted: got %b, required 1", bus.halted); end
      tests++; if (bus.cpu_ce !== 1'b0) begin fails++; $display("FAIL reset_ce: got %b, required 0", bus.cpu_ce); end
      tests++; if (bus.ce_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %h, required 0", bus.ce_count); end
   endtask

   task automatic test_run();
      int n = 0;
      bus.sw_run = 1;
      tick();
      reset = 1;
      do begin tick(); n++; end while (bus.ctrl_state !== S_RUN && n < 100);
      tests++; if (n != 2 + DEB + 1) begin fails++; $display("FAIL run_entry: entered after %0d cycles, required %0d", n, 2 + DEB + 1); end
      k = 0;
      for (int j = 0; j < 20; j++) begin
         tests++;
         if (bus.cpu_ce !== (k % DIV == DIV - 1)) begin fails++; $display("FAIL run_ce k=%0d: got %b, required %b", k, bus.cpu_ce, (k % DIV == DIV - 1)); end
         if (k % DIV == DIV - 1) begin exp_q.push_back('{S_RUN, exp_cnt}); exp_cnt++; end
         tick(); k++;
      end
      tests++; if (bus.ce_count !== 32'd5) begin fails++; $display("FAIL run_count: got %0d, required 5", bus.ce_count); end
   endtask

   task automatic test_halt_req();
      int n = 0;
      while (k % DIV != DIV - 1) begin tick(); k++; end
      bus.halt_req = 1;
      #1;
      tests++; if (bus.cpu_ce !== 1'b0) begin fails++; $display("FAIL halt_ce: got %b, required 0", bus.cpu_ce); end
      tick();
      bus.halt_req = 0;
      tests++; if (bus.ctrl_state !== S_BRK) begin fails++; $display("FAIL halt_state: got %0d, required 3", bus.ctrl_state); end
      tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_halted: got %b, required 1", bus.halted); end
      tests++; if (bus.ce_count !== 32'd5) begin fails++; $display("FAIL halt_count: got %0d, required 5", bus.ce_count); end
      repeat (5) tick();
      tests++; if (bus.ctrl_state !== S_BRK) begin fails++; $display("FAIL break_hold: got %0d, required 3", bus.ctrl_state); end
      bus.btn_step = 1;
      while (bus.ctrl_state !== S_STEP && n < 60) begin tick(); n++; end
      tests++;
      if (bus.ctrl_state !== S_STEP) begin
         fails++; $display("FAIL break_step: no STEP within 60 cycles, state=%0d", bus.ctrl_state);
      end else begin
         exp_q.push_back('{S_STEP, exp_cnt}); exp_cnt++;
         tests++; if (bus.cpu_ce !== 1'b1) begin fails++; $display("FAIL break_step_ce: got %b, required 1", bus.cpu_ce); end
      end
      tick();
      tests++; if (bus.ctrl_state !== S_HALT) begin fails++; $display("FAIL step_to_halt: got %0d, required 0", bus.ctrl_state); end
      tests++; if (bus.ce_count !== 32'd6) begin fails++; $display("FAIL step_count: got %0d, required 6", bus.ce_count); end
      tick();
      tests++; if (bus.ctrl_state !== S_RUN) begin fails++; $display("FAIL rerun: got %0d, required 1", bus.ctrl_state); end
      k = 0;
   endtask

   task automatic test_reset_mid_run();
      while (exp_cnt < 32'h2A && k < 400) begin
         if (k % DIV == DIV - 1) begin exp_q.push_back('{S_RUN, exp_cnt}); exp_cnt++; end
         tick(); k++;
      end
      while (k % DIV != DIV - 1) begin tick(); k++; end
      tests++; if (bus.ce_count !== 32'h2A) begin fails++; $display("FAIL mid_count: got %h, required 0000002a", bus.ce_count); end
      tests++; if (bus.cpu_ce !== 1'b1) begin fails++; $display("FAIL mid_ce_pending: got %b, required 1", bus.cpu_ce); end
      #2 reset = 0;
      #1;
      tests++; if (bus.ce_count !== 32'd0) begin fails++; $display("FAIL async_count: got %h, required 0", bus.ce_count); end
      tests++; if (bus.cpu_ce !== 1'b0) begin fails++; $display("FAIL async_ce: got %b, required 0", bus.cpu_ce); end
      tests++; if (bus.ctrl_state !== S_HALT) begin fails++; $display("FAIL async_state: got %0d, required 0", bus.ctrl_state); end
      bus.sw_run = 0; bus.btn_step = 0;
      exp_cnt = '0;
      repeat (3) tick();
      reset = 1;
      repeat (3) tick();
   endtask

   task automatic test_step_debounce();
      int steps = 0;
      bus.btn_step = 1; tick();
      bus.btn_step = 0; tick();
      bus.btn_step = 1;
      for (int j = 0; j < 100; j++) begin
         tick();
         if (bus.ctrl_state === S_STEP) begin steps++; exp_q.push_back('{S_STEP, exp_cnt}); exp_cnt++; end
      end
      tests++; if (steps != 1) begin fails++; $display("FAIL step_once: got %0d STEP cycles, required 1", steps); end
      tests++; if (bus.ce_count !== 32'd1) begin fails++; $display("FAIL step_count: got %0d, required 1", bus.ce_count); end
      tests++; if (bus.ctrl_state !== S_HALT) begin fails++; $display("FAIL step_back: got %0d, required 0", bus.ctrl_state); end
      bus.btn_step = 0;
      repeat (DEB + 6) tick();
   endtask

   task automatic test_wrap();
      int n = 0;
      force dut.ce_count_q = 32'hFFFF_FFFF;
      tick();
      release dut.ce_count_q;
      #1;
      exp_cnt = 32'hFFFF_FFFF;
      tests++; if (bus.ce_count !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_preset: got %h, required ffffffff", bus.ce_count); end
      bus.btn_step = 1;
      while (bus.ctrl_state !== S_STEP && n < 60) begin tick(); n++; end
      tests++;
      if (bus.ctrl_state !== S_STEP) begin
         fails++; $display("FAIL wrap_step: no STEP within 60 cycles, state=%0d", bus.ctrl_state);
      end else begin
         exp_q.push_back('{S_STEP, exp_cnt}); exp_cnt++;
      end
      tick();
      tests++; if (bus.ce_count !== 32'd0) begin fails++; $display("FAIL wrap_count: got %h, required 00000000", bus.ce_count); end
      bus.btn_step = 0;
      repeat (DEB + 6) tick();
   endtask

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
   task automatic test_breakpoint();
      int n = 0;
      logic adv;
      bus.pc = 32'h0040_0000; bus.bp_addr = 32'h0040_0010; bus.bp_en = 1;
      bus.sw_run = 1;
      while (bus.ctrl_state !== S_RUN && n < 60) begin tick(); n++; end
      k = 0;
      while (bus.ctrl_state === S_RUN && k < 60) begin
         adv = (k % DIV == DIV - 1);
         if (adv) begin exp_q.push_back('{S_RUN, exp_cnt}); exp_cnt++; end
         tick(); k++;
         if (adv) bus.pc = bus.pc + 32'd4;
      end
      tests++; if (bus.ctrl_state !== S_BRK) begin fails++; $display("FAIL bp_state: got %0d, required 3", bus.ctrl_state); end
      tests++; if (bus.pc !== 32'h0040_0010) begin fails++; $display("FAIL bp_pc: stopped at %h, required 00400010", bus.pc); end
      tests++; if (bus.ce_count !== 32'd4) begin fails++; $display("FAIL bp_count: got %0d, required 4", bus.ce_count); end
      bus.sw_run = 0;
      n = 0;
      while (bus.ctrl_state !== S_HALT && n < 60) begin tick(); n++; end
      tests++; if (bus.ctrl_state !== S_HALT) begin fails++; $display("FAIL bp_exit: got %0d, required 0", bus.ctrl_state); end
      bus.bp_en = 0;
   endtask
`else
   task automatic test_no_breakpoint();
      int n = 0;
      bus.pc = 32'h0040_0010; bus.bp_addr = 32'h0040_0010; bus.bp_en = 1;
      bus.sw_run = 1;
      while (bus.ctrl_state !== S_RUN && n < 60) begin tick(); n++; end
      for (k = 0; k < 16; k++) begin
         if (k % DIV == DIV - 1) begin exp_q.push_back('{S_RUN, exp_cnt}); exp_cnt++; end
         tick();
      end
      tests++; if (bus.ctrl_state !== S_RUN) begin fails++; $display("FAIL nobp_state: got %0d, required 1", bus.ctrl_state); end
      tests++; if (bus.ce_count !== 32'd4) begin fails++; $display("FAIL nobp_count: got %0d, required 4", bus.ce_count); end
      bus.sw_run = 0;
      n = 0;
      while (bus.ctrl_state === S_RUN && n < 60) begin
         if (k % DIV == DIV - 1) begin exp_q.push_back('{S_RUN, exp_cnt}); exp_cnt++; end
         tick(); k++; n++;
      end
      tests++; if (bus.ctrl_state !== S_HALT) begin fails++; $display("FAIL nobp_exit: got %0d, required 0", bus.ctrl_state); end
      bus.bp_en = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_run();
      test_halt_req();
      test_reset_mid_run();
      test_step_debounce();
      test_wrap();
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      test_breakpoint();
`else
      test_no_breakpoint();
`endif
      repeat (4) tick();
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL pulses_missing: %0d expected pulses never seen", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL provide parameter DIV, default 4, meaning clk_in cycles per enable pulse in RUN (legal range >= 1).
REQ-002 SHALL provide parameter DEB_CYCLES, default 16, meaning consecutive stable cycles required to accept a new debounced level.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sw_run, input, 1 bit: raw run switch, asynchronous to clk_in.
REQ-006 SHALL have port btn_step, input, 1 bit: raw single-step button, asynchronous to clk_in.
REQ-007 SHALL have port halt_req, input, 1 bit: synchronous halt request from the CPU (e.g. break instruction).
REQ-008 SHALL have port pc, input, 32 bits: current CPU program counter.
REQ-009 SHALL have port bp_addr, input, 32 bits: breakpoint address.
REQ-010 SHALL have port bp_en, input, 1 bit: breakpoint enable.
REQ-011 SHALL have port cpu_ce, output, 1 bit: CPU clock-enable; one high cycle equals one instruction cycle advance.
REQ-012 SHALL have port ctrl_state, output, 2 bits: HALT=00, RUN=01, STEP=10, BREAK=11.
REQ-013 SHALL have port halted, output, 1 bit: high in HALT or BREAK.
REQ-014 SHALL have port ce_count, output, 32 bits: count of cpu_ce pulses issued.

Function
REQ-015 sw_run and btn_step SHALL each pass through a 2-flop synchronizer, then a debouncer updating its level only after DEB_CYCLES consecutive cycles of a stable synchronized value differing from the current level.
REQ-016 A step pulse SHALL be a one-cycle rising edge of debounced btn_step; held button yields exactly one pulse.
REQ-017 HALT: run_db=1 -> RUN; else step pulse -> STEP; else stay.
REQ-018 RUN, priority high to low: halt_req -> BREAK; bp_hit -> BREAK; run_db=0 -> HALT; step pulses ignored.
REQ-019 STEP SHALL last exactly one cycle, then -> HALT unconditionally.
REQ-020 BREAK: step pulse -> STEP; else run_db=0 -> HALT; else stay (switch must be turned off to leave BREAK without stepping).
REQ-021 Rate counter SHALL clear to 0 on every entry to RUN, count 0..DIV-1 in RUN, wrap to 0.
REQ-022 cpu_ce SHALL be high when state=STEP, or state=RUN with counter=DIV-1 and no halt_req or bp_hit that cycle; otherwise low.
REQ-023 First RUN pulse SHALL occur DIV cycles after the RUN-entry edge; with DIV=1, cpu_ce is high every RUN cycle.
REQ-024 ce_count SHALL increment by 1 on each cycle cpu_ce=1, wrapping 0xFFFFFFFF -> 0.
REQ-025 ctrl_state and halted SHALL be decoded from registered state only.

Reset
REQ-026 reset low SHALL asynchronously force state=HALT, cpu_ce=0, ctrl_state=00, halted=1, ce_count=0, rate counter=0, synchronizers and debounced levels=0, regardless of operation in progress.
REQ-027 After reset release with sw_run held high, RUN SHALL be entered only after synchronizer plus DEB_CYCLES latency.

Configuration
REQ-028 With macro CPU_RUN_CTRL_BREAKPOINT_EN defined, bp_hit = bp_en AND (pc == bp_addr), evaluated only in RUN.
REQ-029 Without CPU_RUN_CTRL_BREAKPOINT_EN, bp_hit SHALL be constant 0; pc, bp_addr and bp_en are unused; BREAK is reachable only via halt_req.

Verification
REQ-030 Reset, sw_run=1 held, DIV=4, DEB_CYCLES=16 -> RUN after 2+16 cycles, cpu_ce high every 4th cycle, ce_count=5 after 20 RUN cycles.
REQ-031 HALT, btn_step held high 100 cycles with 3-cycle bounce at start -> exactly one STEP cycle, one cpu_ce pulse, ce_count +1, back to HALT.
REQ-032 RUN, halt_req=1 on a cycle where counter=3 -> cpu_ce stays 0, next state BREAK, halted=1; step pulse -> one cpu_ce, then HALT.
REQ-033 Macro defined, bp_en=1, bp_addr=0x00400010, pc stepping 0x00400000 by 4 per pulse -> BREAK entered when pc=0x00400010, no pulse issued at that pc.
REQ-034 reset asserted low mid-RUN with ce_count=0x0000002A -> immediately ce_count=0, cpu_ce=0, ctrl_state=00.
REQ-035 ce_count preset near wrap (run 0xFFFFFFFF pulses via force) plus one pulse -> ce_count=0x00000000.
